// File: rtl/pe_block_seq.sv
// pe_block_seq: job sequencer for one pe_block.
// A single accepted job is turned into the following control sequence:
//   accumulator clear, a feed window of iTaps cycles, a pipeline drain
//   and a one-cycle result-valid pulse.
// All outputs are registered. An abort from CLEAR/FEED/DRAIN returns the
// sequencer to IDLE and acknowledges the abort with a one-cycle pulse.

module pe_block_seq #(
    parameter int ARRAY_NUM = 3,
    parameter int BLOCK_NUM = 3,
    parameter int PIPE_LAT  = ARRAY_NUM + BLOCK_NUM,
    parameter int TAP_W     = 8
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [TAP_W-1:0]     iTaps,
    input  logic [4:0]           iShift,
    input  logic                 iAbort,
    output logic                 oBusy,
    output logic                 oClearAcc,
    output logic                 oFeedValid,
    output logic [TAP_W-1:0]     oWeightAddr,
    output logic [ARRAY_NUM-2:0] oCfsPassDataLeft,
    output logic [4:0]           oCfsOutputLeftShift,
    output logic                 oResultValid,
    output logic                 oAborted
);

    // Drain counter counts PIPE_LAT-1 down to 0, one DRAIN cycle per value.
    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [TAP_W-1:0] taps_reg;
    logic [4:0]       shift_reg;
    logic [CNT_W-1:0] drain_cnt_reg;

    // The shift config is latched on accept, i.e. exactly when CLEAR is
    // entered, and held afterwards so late readers of pe_block see it.
    assign oCfsOutputLeftShift = shift_reg;

    // Sequencer FSM: state, latched config and all registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg        <= ST_IDLE;
            taps_reg         <= '0;
            shift_reg        <= '0;
            drain_cnt_reg    <= '0;
            oBusy            <= 1'b0;
            oClearAcc        <= 1'b0;
            oFeedValid       <= 1'b0;
            oWeightAddr      <= '0;
            oCfsPassDataLeft <= '0;
            oResultValid     <= 1'b0;
            oAborted         <= 1'b0;
        end else begin
            // Pulse and feed outputs default low; states re-assert them.
            oClearAcc        <= 1'b0;
            oFeedValid       <= 1'b0;
            oWeightAddr      <= '0;
            oCfsPassDataLeft <= '0;
            oResultValid     <= 1'b0;
            oAborted         <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    oBusy <= 1'b0;
                    // iAbort is meaningless here; a start is always taken.
                    if (iStart) begin
                        taps_reg  <= iTaps;
                        shift_reg <= iShift;
                        state_reg <= ST_CLEAR;
                        oBusy     <= 1'b1;
                        oClearAcc <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    if (iAbort) begin
                        state_reg <= ST_IDLE;
                        oBusy     <= 1'b0;
                        oAborted  <= 1'b1;
                    end else if (taps_reg != '0) begin
                        // First feed cycle: address 0, no pass-left yet.
                        state_reg  <= ST_FEED;
                        oFeedValid <= 1'b1;
                    end else begin
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= DRAIN_LOAD;
                    end
                end

                ST_FEED: begin
                    if (iAbort) begin
                        state_reg <= ST_IDLE;
                        oBusy     <= 1'b0;
                        oAborted  <= 1'b1;
                    end else if (oWeightAddr == taps_reg - TAP_W'(1)) begin
                        // The address just presented was the last tap.
                        state_reg     <= ST_DRAIN;
                        drain_cnt_reg <= DRAIN_LOAD;
                    end else begin
                        oFeedValid       <= 1'b1;
                        oWeightAddr      <= oWeightAddr + TAP_W'(1);
                        oCfsPassDataLeft <= '1;
                    end
                end

                ST_DRAIN: begin
                    if (iAbort) begin
                        state_reg <= ST_IDLE;
                        oBusy     <= 1'b0;
                        oAborted  <= 1'b1;
                    end else if (drain_cnt_reg == '0) begin
                        state_reg    <= ST_DONE;
                        oResultValid <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // Results are already flagged; an abort here is too late.
                    state_reg <= ST_IDLE;
                    oBusy     <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    oBusy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_block_seq.sv
// tb_pe_block_seq: self-checking bench for pe_block_seq.
// A timeline model (job start cycle + offsets) predicts every output on
// every cycle; table-driven job scenarios and a few hand sequences check
// the documented timing points, followed by a randomized phase.

module tb_pe_block_seq;

    localparam int ARRAY_NUM = 3;
    localparam int BLOCK_NUM = 3;
    localparam int PIPE_LAT  = 6;
    localparam int TAP_W     = 8;

    logic                 iClk = 1'b0;
    logic                 iRst;
    logic                 iStart;
    logic [TAP_W-1:0]     iTaps;
    logic [4:0]           iShift;
    logic                 iAbort;
    logic                 oBusy;
    logic                 oClearAcc;
    logic                 oFeedValid;
    logic [TAP_W-1:0]     oWeightAddr;
    logic [ARRAY_NUM-2:0] oCfsPassDataLeft;
    logic [4:0]           oCfsOutputLeftShift;
    logic                 oResultValid;
    logic                 oAborted;

    pe_block_seq #(
        .ARRAY_NUM (ARRAY_NUM),
        .BLOCK_NUM (BLOCK_NUM),
        .PIPE_LAT  (PIPE_LAT),
        .TAP_W     (TAP_W)
    ) dut (
        .iClk                (iClk),
        .iRst                (iRst),
        .iStart              (iStart),
        .iTaps               (iTaps),
        .iShift              (iShift),
        .iAbort              (iAbort),
        .oBusy               (oBusy),
        .oClearAcc           (oClearAcc),
        .oFeedValid          (oFeedValid),
        .oWeightAddr         (oWeightAddr),
        .oCfsPassDataLeft    (oCfsPassDataLeft),
        .oCfsOutputLeftShift (oCfsOutputLeftShift),
        .oResultValid        (oResultValid),
        .oAborted            (oAborted)
    );

    always #5 iClk = ~iClk;

    int checks      = 0;
    int failures    = 0;
    int fail_prints = 0;

    // Timeline model: the current cycle, the active job's accept cycle
    // (-1 when none), its tap count, the held shift and the abort-ack cycle.
    int cyc       = 0;
    int job_t     = -1;
    int job_n     = 0;
    int m_shift   = 0;
    int abort_cyc = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
            end
        end
    endtask

    // Advance one clock, update the model from this cycle's inputs, then
    // compare every output with the model just after the edge.
    task automatic step();
        int  off;
        bit  act;
        int  e_addr;
        bit  e_feed;
        @(posedge iClk);
        off = cyc - job_t;
        act = (job_t >= 0) && (off >= 1) && (off <= 2 + job_n + PIPE_LAT);
        if (iRst) begin
            job_t     = -1;
            m_shift   = 0;
            abort_cyc = -1;
        end else if (act && (off <= 1 + job_n + PIPE_LAT) && iAbort) begin
            job_t     = -1;
            abort_cyc = cyc + 1;
        end else if (!act && iStart) begin
            job_t   = cyc;
            job_n   = int'(iTaps);
            m_shift = int'(iShift);
        end
        cyc++;
        #1;
        off    = cyc - job_t;
        act    = (job_t >= 0) && (off >= 1) && (off <= 2 + job_n + PIPE_LAT);
        e_feed = act && (off >= 2) && (off <= 1 + job_n);
        e_addr = e_feed ? off - 2 : 0;
        chk("m_busy",   oBusy,        act);
        chk("m_clear",  oClearAcc,    act && (off == 1));
        chk("m_feed",   oFeedValid,   e_feed);
        chk("m_addr",   oWeightAddr,  e_addr);
        chk("m_pass",   oCfsPassDataLeft, (e_feed && off >= 3) ? 3 : 0);
        chk("m_shift",  oCfsOutputLeftShift, m_shift);
        chk("m_result", oResultValid, act && (off == 2 + job_n + PIPE_LAT));
        chk("m_abort",  oAborted,     cyc == abort_cyc);
    endtask

    typedef struct {
        string name;
        int    taps;
        int    shift;
        int    abort_off;   // cycle (relative to accept) with iAbort=1, -1 none
        int    exp_res;     // expected oResultValid cycle, -1 none
        int    exp_ab;      // expected oAborted cycle, -1 none
        int    exp_feeds;   // number of oFeedValid cycles
        int    exp_maxaddr; // last fed address, -1 none
        int    exp_idle;    // first cycle with oBusy=0
    } vec_t;

    vec_t vecs[9];

    initial begin
        int k, res, ab, feeds, maxaddr, idle, sh_next;
        int res_a, res_b;

        vecs[0] = '{"basic4",      4,   5, -1,  12, -1,   4,   3,  13};
        vecs[1] = '{"taps0",       0,   3, -1,   8, -1,   0,  -1,   9};
        vecs[2] = '{"taps1",       1,  31, -1,   9, -1,   1,   0,  10};
        vecs[3] = '{"abort_feed",  4,   5,  4,  -1,  5,   3,   2,   5};
        vecs[4] = '{"abort_clear", 3,   2,  1,  -1,  2,   0,  -1,   2};
        vecs[5] = '{"abort_drain", 2,   6,  6,  -1,  7,   2,   1,   7};
        vecs[6] = '{"abort_done",  2,   4, 10,  10, -1,   2,   1,  11};
        vecs[7] = '{"abort_start", 2,   9,  0,  10, -1,   2,   1,  11};
        vecs[8] = '{"taps_max",  255,   1, -1, 263, -1, 255, 254, 264};

        iRst = 1'b1; iStart = 1'b0; iTaps = '0; iShift = '0; iAbort = 1'b0;
        repeat (3) step();
        chk("reset_state", {oBusy, oClearAcc, oFeedValid, oWeightAddr, oCfsPassDataLeft,
                            oCfsOutputLeftShift, oResultValid, oAborted}, 0);
        iRst = 1'b0;
        step();

        // Table-driven job scenarios.
        foreach (vecs[i]) begin
            iStart = 1'b1;
            iTaps  = TAP_W'(vecs[i].taps);
            iShift = 5'(vecs[i].shift);
            iAbort = (vecs[i].abort_off == 0);
            k = 0; res = -1; ab = -1; feeds = 0; maxaddr = -1; idle = -1;
            while (k < 400 && (idle < 0 || k < idle + 3)) begin
                step();
                k++;
                iStart = 1'b0;
                iAbort = (k == vecs[i].abort_off);
                if (k == 1) begin
                    chk({vecs[i].name, "_clear1"}, oClearAcc, 1);
                    chk({vecs[i].name, "_shift1"}, oCfsOutputLeftShift, vecs[i].shift);
                end
                if (oResultValid) res = k;
                if (oAborted) ab = k;
                if (oFeedValid) begin
                    feeds++;
                    maxaddr = int'(oWeightAddr);
                end
                if (!oBusy && idle < 0) idle = k;
            end
            iAbort = 1'b0;
            chk({vecs[i].name, "_result_cycle"}, res, vecs[i].exp_res);
            chk({vecs[i].name, "_abort_cycle"}, ab, vecs[i].exp_ab);
            chk({vecs[i].name, "_feed_cycles"}, feeds, vecs[i].exp_feeds);
            chk({vecs[i].name, "_max_addr"}, maxaddr, vecs[i].exp_maxaddr);
            chk({vecs[i].name, "_idle_cycle"}, idle, vecs[i].exp_idle);
            $display("vector %s: result@%0d abort@%0d feeds=%0d idle@%0d",
                     vecs[i].name, res, ab, feeds, idle);
        end

        // Held start, taps=2: accepts at 0 and 11, shift changes while busy ignored.
        iStart = 1'b1; iTaps = 8'd2; iShift = 5'd7;
        res_a = -1; res_b = -1; sh_next = 7;
        for (int j = 1; j <= 23; j++) begin
            step();
            if (oResultValid) begin
                if (res_a < 0) res_a = j;
                else if (res_b < 0) res_b = j;
            end
            if (j == 5)  chk("held_shift_busy", oCfsOutputLeftShift, 7);
            if (j == 11) chk("held_idle_gap", oBusy, 0);
            if (j == 12) chk("held_shift_second", oCfsOutputLeftShift, sh_next);
            if (j < 11) begin
                iShift  = 5'((j * 3 + 1) % 32);
                sh_next = (j * 3 + 1) % 32;
            end
        end
        iStart = 1'b0;
        chk("held_result_first", res_a, 10);
        chk("held_result_second", res_b, 21);
        $display("sequence held_start: results@%0d,%0d", res_a, res_b);
        repeat (12) step();

        // Abort in third feed cycle, then a new start in the abort-ack cycle.
        iStart = 1'b1; iTaps = 8'd4; iShift = 5'd5;
        for (int j = 1; j <= 20; j++) begin
            step();
            iStart = (j == 5);
            iAbort = (j == 4);
            if (j == 4) iTaps = 8'd1;
            if (j == 4) iShift = 5'd12;
            if (j == 5) begin
                chk("abrst_aborted", oAborted, 1);
                chk("abrst_feed_drop", oFeedValid, 0);
                chk("abrst_addr_zero", oWeightAddr, 0);
                chk("abrst_shift_kept", oCfsOutputLeftShift, 5);
            end
            if (j == 6) begin
                chk("abrst_new_clear", oClearAcc, 1);
                chk("abrst_new_shift", oCfsOutputLeftShift, 12);
            end
        end
        iStart = 1'b0; iAbort = 1'b0;
        $display("sequence abort_restart: done");
        repeat (5) step();

        // Reset during cycle 7 of a taps=4 job: everything zero from cycle 8.
        iStart = 1'b1; iTaps = 8'd4; iShift = 5'd5;
        res = -1;
        for (int j = 1; j <= 25; j++) begin
            step();
            iStart = 1'b0;
            iRst   = (j == 7);
            if (oResultValid) res = j;
            if (j == 8)
                chk("rst_all_zero", {oBusy, oClearAcc, oFeedValid, oWeightAddr, oCfsPassDataLeft,
                                     oCfsOutputLeftShift, oResultValid, oAborted}, 0);
        end
        iRst = 1'b0;
        chk("rst_no_result", res, -1);
        $display("sequence reset_mid_job: result@%0d", res);

        // Randomized phase against the timeline model.
        for (int j = 0; j < 3000; j++) begin
            iStart = ($urandom_range(0, 3) == 0);
            iTaps  = ($urandom_range(0, 15) == 0) ? TAP_W'($urandom_range(0, 255))
                                                  : TAP_W'($urandom_range(0, 6));
            iShift = 5'($urandom_range(0, 31));
            iAbort = ($urandom_range(0, 29) == 0);
            iRst   = ($urandom_range(0, 299) == 0);
            step();
        end
        $display("random phase: 3000 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
